mem_access_unit: RTL and testbench

// - Single-port load/store sequencer: one per SIC port, directly upstream of the locked data memory.
// - Takes one memory op from the issue stage and drives the memory's per-port req/id/addr/wdata.
// - Waits for grant, captures read data, pulses release_lock, returns the result with valid/ready.
// - Lock is held only between the grant cycle and the release pulse. Ordering comes from issue_id.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Single-port load/store sequencer that sits in front of one port of the
// locked data memory. It accepts one op from the issue stage and drives the
// memory port. It waits for the grant, captures the load data, pulses
// release_lock for one cycle and then returns the result on a valid/ready
// handshake. The lock is held only from the grant cycle to the release pulse.
//
// Optional feature macro: MAU_SUBWORD_LOAD_EN
//   defined   : byte/half loads are supported. The lane is picked by
//               addr[1:0] (little-endian) and sign- or zero-extended. The
//               memory sees a word-aligned address. Sub-word stores are
//               still errors.
//   undefined : any op_size other than word is reported as an error.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   op_valid/op_ready               op handshake (ready only in IDLE)
//   op_is_store, op_size,
//   op_unsigned, op_addr,
//   op_wdata, op_issue_id           op fields, latched on acceptance
//   flush                           squash the in-flight op
//   mem_addr, mem_req_read,
//   mem_req_write, mem_issue_id,
//   mem_release, mem_wdata          per-port request to the memory
//   mem_rdata, mem_grant            per-port response from the memory
//   res_valid/res_ready             result handshake
//   res_rdata, res_err              load data (0 for stores), access error
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_is_store,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic [31:0]         op_addr,
    input  logic [31:0]         op_wdata,
    input  logic [ID_WIDTH-1:0] op_issue_id,
    input  logic                flush,
    output logic [31:0]         mem_addr,
    output logic                mem_req_read,
    output logic                mem_req_write,
    output logic [ID_WIDTH-1:0] mem_issue_id,
    output logic                mem_release,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_grant,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_rdata,
    output logic                res_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]          state_reg,    state_next;
    logic [31:0]         addr_reg,     addr_next;
    logic [1:0]          size_reg,     size_next;
    logic                unsigned_reg, unsigned_next;
    logic                store_reg,    store_next;
    logic [31:0]         wdata_reg,    wdata_next;
    logic [ID_WIDTH-1:0] id_reg,       id_next;
    logic [31:0]         rdata_reg,    rdata_next;
    logic                err_reg,      err_next;

    logic                op_err;
    logic [31:0]         load_data;
    logic [31:0]         req_addr;

    // Decide at acceptance time whether the op may touch the memory at all;
    // erroring ops never request the lock.
    always_comb begin
        op_err = 1'b0;
        if (op_size == 2'd3) begin
            op_err = 1'b1;
        end
`ifdef MAU_SUBWORD_LOAD_EN
        if (op_is_store && op_size != 2'd2) begin
            op_err = 1'b1;
        end
`else
        if (op_size != 2'd2) begin
            op_err = 1'b1;
        end
`endif
        if (op_size == 2'd2 && op_addr[1:0] != 2'b00) begin
            op_err = 1'b1;
        end
        if (op_size == 2'd1 && op_addr[0]) begin
            op_err = 1'b1;
        end
    end

`ifdef MAU_SUBWORD_LOAD_EN
    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = mem_rdata[8*gi +: 8];
    end

    assign byte_sel = byte_lane[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign req_addr = {addr_reg[31:2], 2'b00};

    always_comb begin
        case (size_reg)
            2'd0:    load_data = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
            2'd1:    load_data = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end
`else
    // Only word loads reach the memory in this build, so the size and sign
    // fields carry no information past acceptance.
    logic unused_subword;
    assign unused_subword = ^{size_reg, unsigned_reg};
    assign load_data      = mem_rdata;
    assign req_addr       = addr_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        size_next     = size_reg;
        unsigned_next = unsigned_reg;
        store_next    = store_reg;
        wdata_next    = wdata_reg;
        id_next       = id_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    addr_next     = op_addr;
                    size_next     = op_size;
                    unsigned_next = op_unsigned;
                    store_next    = op_is_store;
                    wdata_next    = op_wdata;
                    id_next       = op_issue_id;
                    rdata_next    = 32'd0;
                    err_next      = op_err;
                    state_next    = op_err ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                // A grant wins over a simultaneous flush: the lock is already
                // taken and a store has committed, so it must be released.
                if (mem_grant) begin
                    rdata_next = store_reg ? 32'd0 : load_data;
                    state_next = ST_RELEASE;
                end else if (flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                state_next = flush ? ST_IDLE : ST_RESP;
            end
            default: begin
                if (flush || res_ready) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= 32'd0;
            size_reg     <= 2'd0;
            unsigned_reg <= 1'b0;
            store_reg    <= 1'b0;
            wdata_reg    <= 32'd0;
            id_reg       <= '0;
            rdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            size_reg     <= size_next;
            unsigned_reg <= unsigned_next;
            store_reg    <= store_next;
            wdata_reg    <= wdata_next;
            id_reg       <= id_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
        end
    end

    // Memory-side outputs are qualified by state so the port is quiet
    // whenever no request is outstanding.
    assign op_ready      = (state_reg == ST_IDLE);
    assign mem_req_read  = (state_reg == ST_REQ) && !store_reg;
    assign mem_req_write = (state_reg == ST_REQ) &&  store_reg;
    assign mem_addr      = (state_reg == ST_REQ) ? req_addr : 32'd0;
    assign mem_issue_id  = (state_reg == ST_REQ) ? id_reg : '0;
    assign mem_wdata     = mem_req_write ? wdata_reg : 32'd0;
    assign mem_release   = (state_reg == ST_RELEASE);
    assign res_valid     = (state_reg == ST_RESP);
    assign res_rdata     = res_valid ? rdata_reg : 32'd0;
    assign res_err       = res_valid && err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed and randomized bench for mem_access_unit. The bench plays the role
// of both the issue stage and the locked memory port. Expected error flags,
// load results and memory addresses come from a small arithmetic model of the
// access rules. Build with +define+MAU_SUBWORD_LOAD_EN to exercise sub-word
// loads.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           op_valid, op_ready, op_is_store, op_unsigned, flush;
    logic [1:0]     op_size;
    logic [31:0]    op_addr, op_wdata;
    logic [IDW-1:0] op_issue_id;
    logic [31:0]    mem_addr, mem_wdata, mem_rdata;
    logic           mem_req_read, mem_req_write, mem_release, mem_grant;
    logic [IDW-1:0] mem_issue_id;
    logic           res_valid, res_ready, res_err;
    logic [31:0]    res_rdata;

    int errors = 0;
    int checks = 0;
    int op_count = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ID_WIDTH(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_issue_id(op_issue_id), .flush(flush),
        .mem_addr(mem_addr), .mem_req_read(mem_req_read),
        .mem_req_write(mem_req_write), .mem_issue_id(mem_issue_id),
        .mem_release(mem_release), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_grant(mem_grant),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_rdata(res_rdata), .res_err(res_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model of the access rules ----
    function automatic logic model_err(input logic st, input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
`ifdef MAU_SUBWORD_LOAD_EN
        if (st && sz != 2'd2) return 1'b1;
`else
        if (sz != 2'd2) return 1'b1;
`endif
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic st, input logic [1:0] sz,
                                                input logic uns, input logic [31:0] a,
                                                input logic [31:0] word);
        logic [31:0] v;
        if (st) return 32'd0;
        if (sz == 2'd0) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (word >> (8 * (a % 4))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
        end
        return word;
    endfunction

    function automatic logic [31:0] model_maddr(input logic [31:0] a);
`ifdef MAU_SUBWORD_LOAD_EN
        return a - (a % 4);
`else
        return a;
`endif
    endfunction

    // Offer one op, serve the memory port after gdly wait cycles, and hold
    // res_ready low for rdly cycles. Entered and left at posedge+1 in IDLE.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [IDW-1:0] id, input logic [31:0] word,
                          input int gdly, input int rdly);
        logic        e;
        logic [31:0] r;
        e = model_err(st, sz, a);
        r = e ? 32'd0 : model_rdata(st, sz, uns, a, word);
        chk("idle_op_ready", op_ready, 1);
        op_valid = 1'b1; op_is_store = st; op_size = sz; op_unsigned = uns;
        op_addr = a; op_wdata = wd; op_issue_id = id;
        tick();
        // Scramble the op inputs so that held request fields are really latched.
        op_valid = 1'b0; op_addr = $urandom; op_wdata = $urandom;
        op_issue_id = IDW'($urandom); op_is_store = ~st;
        if (!e) begin
            for (int i = 0; i <= gdly; i++) begin
                chk("req_read", mem_req_read, !st);
                chk("req_write", mem_req_write, st);
                chk("req_addr", mem_addr, model_maddr(a));
                chk("req_id", mem_issue_id, 32'(id));
                if (st) chk("req_wdata", mem_wdata, wd);
                chk("req_no_release", mem_release, 0);
                chk("req_no_valid", res_valid, 0);
                chk("req_op_ready", op_ready, 0);
                if (i == gdly) begin
                    mem_grant = 1'b1;
                    mem_rdata = word;
                end
                tick();
                mem_grant = 1'b0;
                mem_rdata = $urandom;
            end
            chk("rel_pulse", mem_release, 1);
            chk("rel_no_read", mem_req_read, 0);
            chk("rel_no_write", mem_req_write, 0);
            chk("rel_no_valid", res_valid, 0);
            tick();
        end
        for (int k = 0; k <= rdly; k++) begin
            chk("resp_valid", res_valid, 1);
            chk("resp_err", res_err, e);
            chk("resp_rdata", res_rdata, r);
            chk("resp_op_ready", op_ready, 0);
            chk("resp_release", mem_release, 0);
            chk("resp_no_req", mem_req_read | mem_req_write, 0);
            res_ready = (k == rdly);
            tick();
        end
        res_ready = 1'b0;
        chk("done_valid", res_valid, 0);
        chk("done_op_ready", op_ready, 1);
        op_count++;
        $display("op %0d: store=%0d size=%0d uns=%0d addr=0x%08h grant_wait=%0d ready_wait=%0d exp_err=%0d exp_rdata=0x%08h got_err=%0d got_rdata=0x%08h",
                 op_count, st, sz, uns, a, gdly, rdly, e, r, res_err, res_rdata);
    endtask

    initial begin
        logic       r_st, r_uns;
        logic [1:0] r_sz;

        rst_n = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_size = 2'd2;
        op_unsigned = 1'b0; op_addr = 32'd0; op_wdata = 32'd0; op_issue_id = '0;
        flush = 1'b0; mem_rdata = 32'd0; mem_grant = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_req_read", mem_req_read, 0);
        chk("rst_req_write", mem_req_write, 0);
        chk("rst_release", mem_release, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'h3, 32'hDEADBEEF, 3, 0);
        run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 4'h5, 32'hCAFEF00D, 0, 0);
        run_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 4'h1, 32'h0, 0, 0);
        run_op(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 4'h2, 32'h0, 0, 0);
        run_op(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 4'h7, 32'hA5A5_1234, 1, 5);
        run_op(1'b1, 2'd0, 1'b0, 32'h48, 32'hFF, 4'h8, 32'h0, 0, 0);
`ifdef MAU_SUBWORD_LOAD_EN
        run_op(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 4'h9, 32'h80FF0011, 0, 0);
        chk("dir_sbyte", res_rdata, 32'h0); // result dropped after handshake
        run_op(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 4'hA, 32'h80FF0011, 2, 1);
        run_op(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 4'hB, 32'h80FF0011, 0, 0);
`else
        run_op(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 4'h9, 32'h80FF0011, 0, 0);
        run_op(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 4'hA, 32'h80FF0011, 0, 0);
`endif

        // flush in IDLE: the offered op is not accepted
        op_valid = 1'b1; op_is_store = 1'b0; op_size = 2'd2; op_addr = 32'h80;
        flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_op_ready", op_ready, 1);
        chk("fl_idle_no_req", mem_req_read | mem_req_write, 0);
        chk("fl_idle_no_valid", res_valid, 0);
        $display("op flush-idle: op_ready=%0d", op_ready);

        // flush in REQ before grant: back to IDLE, never released
        op_valid = 1'b1; op_is_store = 1'b0; op_size = 2'd2; op_addr = 32'h84;
        tick();
        op_valid = 1'b0;
        chk("fl_req_read", mem_req_read, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_op_ready", op_ready, 1);
        chk("fl_req_no_release", mem_release, 0);
        tick();
        chk("fl_req_no_release2", mem_release, 0);
        chk("fl_req_no_valid", res_valid, 0);
        $display("op flush-req: op_ready=%0d release=%0d", op_ready, mem_release);

        // flush in RELEASE: pulse still happens once, no result
        op_valid = 1'b1; op_is_store = 1'b0; op_size = 2'd2; op_addr = 32'h88;
        tick();
        op_valid = 1'b0;
        mem_grant = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_grant = 1'b0;
        chk("fl_rel_pulse", mem_release, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_rel_once", mem_release, 0);
        chk("fl_rel_no_valid", res_valid, 0);
        chk("fl_rel_op_ready", op_ready, 1);
        tick();
        chk("fl_rel_no_valid2", res_valid, 0);
        $display("op flush-release: res_valid=%0d op_ready=%0d", res_valid, op_ready);

        // flush in RESP: result dropped
        op_valid = 1'b1; op_is_store = 1'b0; op_size = 2'd2; op_addr = 32'h8D;
        tick();
        op_valid = 1'b0;
        chk("fl_resp_valid", res_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_resp_dropped", res_valid, 0);
        chk("fl_resp_op_ready", op_ready, 1);
        $display("op flush-resp: res_valid=%0d", res_valid);

        // reset in the middle of an op drops it
        op_valid = 1'b1; op_is_store = 1'b1; op_size = 2'd2; op_addr = 32'h90;
        tick();
        op_valid = 1'b0;
        chk("mr_req_write", mem_req_write, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_op_ready", op_ready, 1);
        chk("mr_no_req", mem_req_read | mem_req_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mr_idle", op_ready, 1);
        $display("op mid-reset: op_ready=%0d", op_ready);

        // Randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            r_st  = 1'($urandom);
            r_uns = 1'($urandom);
            r_sz  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
            if (r_st && $urandom_range(0, 3) != 0) r_sz = 2'd2;
            run_op(r_st, r_sz, r_uns,
                   ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                   $urandom, IDW'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
